timer_sample_arb: RTL and testbench
===================================

# timer_sample_arb

Sampling arbiter and sequencer for the 64-bit timer counter core.
- Shares the core's single sample port among `N_REQ` requesters through a req/ack handshake.
- Drives the core's `TIMER_SAMPLE` strobe, captures the returned `TIMER_VALUE`, and delivers a timestamp to the granted requester.
- Registers the count-enable and generates the counter clear.
- Sits between the timer core and the software-register/peripheral clients that need timestamps.

## Interface
Parameters:
- `DATA_W`, 32: half-width of the timer count; timestamp is `2*DATA_W`.
- `N_REQ`, 4: number of requesters, 2..16.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted at 0).
- `req`  in  `N_REQ`  per-requester timestamp request (level).
- `ack`  out  `N_REQ`  one-hot, one-cycle grant-complete pulse.
- `tstamp`  out  `2*DATA_W`  captured timestamp; valid in the `ack` cycle and held until the next capture.
- `grant_id`  out  `$clog2(N_REQ)`  index of the current or last granted requester.
- `busy`  out  1  high while a transaction is in flight (state is not IDLE).
- `en`  in  1  software count enable.
- `clr`  in  1  software counter clear request (pulse).
- `TIMER_ENABLE`  out  1  to core; registered copy of `en`.
- `TIMER_SAMPLE`  out  1  to core; one-cycle sample strobe.
- `TIMER_RST`  out  1  to core; active-high counter clear, one cycle.
- `TIMER_VALUE`  in  `2*DATA_W`  from core; sampled counter register.

## Operation
FSM states are IDLE, SAMPLE, WAIT and ACK. Each state lasts exactly one cycle except IDLE.
- **IDLE:** if `req != 0`, arbitrate, register `grant_id`, and go to SAMPLE. Otherwise stay in IDLE.
- **SAMPLE:** `TIMER_SAMPLE=1`. The core loads its counter register on the closing edge. Go to WAIT.
- **WAIT:** `TIMER_VALUE` is now valid. Register `tstamp <= TIMER_VALUE` on the closing edge. Go to ACK.
- **ACK:** `ack[grant_id]=1`, `tstamp` valid. Go to IDLE.

Handshake rules:
- A requester holds `req` until it sees `ack`, then deasserts it on the following cycle.
- A `req` still high in IDLE after `ack` counts as a new request.
- If `req` drops mid-transaction, the transaction still completes and `ack` still pulses; the requester ignores it.
- `req` changes outside IDLE have no effect on the current grant.

Control outputs:
- `TIMER_ENABLE`: `en` registered every cycle, independent of the FSM.
- `TIMER_RST`: `clr` registered every cycle (one-cycle delay), independent of the FSM.
- If `TIMER_RST` and `TIMER_SAMPLE` are both high in the same cycle, the core captures the pre-clear count. The block does not reorder them.
- `ack` is never asserted outside ACK, and never on more than one bit.

## Timing
- Reset values: state IDLE; `ack=0`, `tstamp=0`, `grant_id=0`, `busy=0`, `TIMER_ENABLE=0`, `TIMER_SAMPLE=0`, `TIMER_RST=0`; round-robin pointer 0.
- Latency: `req` high in IDLE at cycle 0 → `TIMER_SAMPLE` at cycle 1 → `ack` at cycle 3. The timestamp equals the count at the end of cycle 1.
- Throughput: one transaction per 4 cycles with continuous requests.
- `busy` is high in cycles 1–3 of each transaction.
- `rst` asserted mid-transaction: the FSM aborts immediately to reset values, and no `ack` is issued.

## Configuration
- `TIMER_SAMPLE_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at `grant_id+1` (mod `N_REQ`); the pointer updates on each grant.
  - Every requester holding `req` is served within `N_REQ` transactions.
- Undefined: fixed priority, lowest index wins. The pointer logic is absent.

## Test plan
- **Single request:** `en=1`, `req=4'b0010` at cycle 0 → `TIMER_SAMPLE` at cycle 1, `ack=4'b0010` at cycle 3, `tstamp` equals counter value at cycle 1, `grant_id=1`.
- **Contention:** `req=4'b1111` held. With RR_EN → ack order 0,1,2,3,0 at cycles 3,7,11,15,19. Without → `ack=4'b0001` every 4 cycles.
- **Disabled counter:** `en=0`, two back-to-back requests → identical `tstamp`. With `en=1` → second `tstamp` exceeds first by 4.
- **Clear:** `clr` pulse at cycle 10 → `TIMER_RST` at cycle 11. A subsequent sample returns a small value, under 10.
- **Reset mid-transaction:** `rst=0` during WAIT → no `ack`, all outputs 0. After release, a new request completes normally in 3 cycles.
- **Requester drop:** `req[2]` drops in SAMPLE → `ack[2]` still pulses at cycle 3, FSM returns to IDLE, and no second grant is issued.

Source files
------------

// File: rtl/timer_sample_arb.sv
// timer_sample_arb: shares the timer core's single sample port among N_REQ
// requesters, sequences the TIMER_SAMPLE strobe, captures TIMER_VALUE and
// returns it as a timestamp with a one-cycle ack. Also registers the count
// enable and the counter clear toward the core.
// Optional feature: define TIMER_SAMPLE_ARB_RR_EN for round-robin arbitration;
// without it, arbitration is fixed priority (lowest index wins).
module timer_sample_arb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_REQ  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         ack,
  output logic [2*DATA_W-1:0]      tstamp,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  input  logic                     en,
  input  logic                     clr,
  output logic                     TIMER_ENABLE,
  output logic                     TIMER_SAMPLE,
  output logic                     TIMER_RST,
  input  logic [2*DATA_W-1:0]      TIMER_VALUE
);

  localparam int unsigned TS_W = 2 * DATA_W;
  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ACK_ONE = N_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   start_idx;
  logic [ID_W-1:0]   pick_id;
  logic              pick_found;
  logic [ID_W-1:0]   grant_d;
  logic [N_REQ-1:0]  ack_d;
  logic [TS_W-1:0]   tstamp_d;
  logic              sample_d;
  logic              busy_d;
  logic              grant_now;

  // A new grant happens only from IDLE with at least one request pending.
  assign grant_now = (state_q == S_IDLE) && (|req);

`ifdef TIMER_SAMPLE_ARB_RR_EN
  logic [ID_W-1:0] rr_ptr;

  // Rotate the search start to one past the requester just granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (grant_now) begin
      rr_ptr <= ((32'(pick_id) + 32'd1) == N_REQ) ? '0 : ID_W'(32'(pick_id) + 32'd1);
    end
  end

  assign start_idx = rr_ptr;
`else
  assign start_idx = '0;
`endif

  // First active request found when scanning upward (modulo N_REQ) from start_idx.
  always_comb begin
    pick_id    = '0;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!pick_found && req[ID_W'((32'(start_idx) + i) % N_REQ)]) begin
        pick_id    = ID_W'((32'(start_idx) + i) % N_REQ);
        pick_found = 1'b1;
      end
    end
  end

  // Next state plus next values of the registered transaction outputs.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_id;
    tstamp_d = tstamp;
    case (state_q)
      S_IDLE: begin
        if (grant_now) begin
          state_d = S_SAMPLE;
          grant_d = pick_id;
        end
      end
      S_SAMPLE: state_d = S_WAIT;
      S_WAIT: begin
        state_d  = S_ACK;
        tstamp_d = TIMER_VALUE;
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    sample_d = (state_d == S_SAMPLE);
    busy_d   = (state_d != S_IDLE);
    ack_d    = (state_d == S_ACK) ? (ACK_ONE << grant_d) : '0;
  end

  // Transaction state and outputs; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      grant_id     <= '0;
      tstamp       <= '0;
      ack          <= '0;
      busy         <= 1'b0;
      TIMER_SAMPLE <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id     <= grant_d;
      tstamp       <= tstamp_d;
      ack          <= ack_d;
      busy         <= busy_d;
      TIMER_SAMPLE <= sample_d;
    end
  end

  // Count enable and clear to the core, registered independently of the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      TIMER_ENABLE <= 1'b0;
      TIMER_RST    <= 1'b0;
    end else begin
      TIMER_ENABLE <= en;
      TIMER_RST    <= clr;
    end
  end

endmodule

// File: tb/tb_timer_sample_arb.sv
// Bench for timer_sample_arb: a simple timer-core model feeds TIMER_VALUE, and
// a transaction-level reference model predicts every output each cycle.
module tb_timer_sample_arb;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req = '0;
  logic          en  = 1'b0;
  logic          clr = 1'b0;
  logic [N-1:0]  ack;
  logic [2*DW-1:0] tstamp;
  logic [1:0]    grant_id;
  logic          busy;
  logic          TIMER_ENABLE, TIMER_SAMPLE, TIMER_RST;
  logic [2*DW-1:0] TIMER_VALUE;

  int n_checks = 0;
  int n_fail   = 0;

  timer_sample_arb #(.DATA_W(DW), .N_REQ(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .ack          (ack),
    .tstamp       (tstamp),
    .grant_id     (grant_id),
    .busy         (busy),
    .en           (en),
    .clr          (clr),
    .TIMER_ENABLE (TIMER_ENABLE),
    .TIMER_SAMPLE (TIMER_SAMPLE),
    .TIMER_RST    (TIMER_RST),
    .TIMER_VALUE  (TIMER_VALUE)
  );

  always #5 clk = ~clk;

  // Timer core: free-running counter with clear, sample register loaded on strobe.
  logic [63:0] core_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_cnt    <= '0;
      TIMER_VALUE <= '0;
    end else begin
      if (TIMER_RST)         core_cnt <= '0;
      else if (TIMER_ENABLE) core_cnt <= core_cnt + 64'd1;
      if (TIMER_SAMPLE)      TIMER_VALUE <= core_cnt;
    end
  end

  // Reference model: phase = cycles into the current transaction (0 = idle).
  int          m_phase, m_gid, m_ptr;
  logic [63:0] m_cnt, m_cap, m_ts;
  logic        m_ten, m_trst;

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_gid = 0; m_ptr = 0;
    m_cnt = '0; m_cap = '0; m_ts = '0;
    m_ten = 1'b0; m_trst = 1'b0;
  endtask

  task automatic model_advance(input logic [N-1:0] r, input logic e, input logic c);
    logic [63:0] cnt_next;
    cnt_next = m_trst ? 64'd0 : (m_ten ? m_cnt + 64'd1 : m_cnt);
    case (m_phase)
      0: if (r != 0) begin
           m_gid = pick(r, m_ptr);
`ifdef TIMER_SAMPLE_ARB_RR_EN
           m_ptr = (m_gid + 1) % N;
`endif
           m_phase = 1;
         end
      1: begin m_cap = m_cnt; m_phase = 2; end
      2: begin m_ts = m_cap; m_phase = 3; end
      default: m_phase = 0;
    endcase
    m_cnt  = cnt_next;
    m_ten  = e;
    m_trst = c;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ack",      64'(ack), (m_phase == 3) ? (64'd1 << m_gid) : 64'd0);
    chk("busy",     64'(busy), 64'(m_phase != 0));
    chk("sample",   64'(TIMER_SAMPLE), 64'(m_phase == 1));
    chk("grant_id", 64'(grant_id), 64'(m_gid));
    chk("tstamp",   tstamp, m_ts);
    chk("enable",   64'(TIMER_ENABLE), 64'(m_ten));
    chk("timer_rst", 64'(TIMER_RST), 64'(m_trst));
  endtask

  // One clock: capture the inputs seen by the edge, advance model, compare.
  task automatic step();
    logic [N-1:0] r;
    logic e, c, live;
    r = req; e = en; c = clr; live = rst;
    @(posedge clk);
    #1;
    if (live) model_advance(r, e, c);
    else      model_reset();
    check_all();
  endtask

  task automatic apply_reset();
    rst = 1'b0; req = '0; en = 1'b0; clr = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         en;
    logic         clr;
    logic [N-1:0] ack;
    logic         busy;
    logic         sample;
    logic [1:0]   gid;
    logic         trst;
  } vec_t;

  vec_t tbl [11];
  int   ack_cyc [$];
  logic [N-1:0] ack_val [$];
  logic [63:0]  ts_q [$];
  int   exp_ord [5];

  initial begin
    // Single request, clear pulse, and a requester dropping req in SAMPLE.
    tbl[0]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0};
    tbl[1]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd1, 1'b0};
    tbl[2]  = '{4'b0010, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd1, 1'b0};
    tbl[3]  = '{4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[4]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b1};
    tbl[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd1, 1'b0};
    tbl[6]  = '{4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0};
    tbl[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 2'd2, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0};
    tbl[9]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0};
    tbl[10] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0};

`ifdef TIMER_SAMPLE_ARB_RR_EN
    exp_ord = '{0, 1, 2, 3, 0};
`else
    exp_ord = '{0, 0, 0, 0, 0};
`endif

    model_reset();
    apply_reset();

    for (int i = 0; i < 11; i++) begin
      req = tbl[i].req; en = tbl[i].en; clr = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d_ack", i),    64'(ack),          64'(tbl[i].ack));
      chk($sformatf("tbl%0d_busy", i),   64'(busy),         64'(tbl[i].busy));
      chk($sformatf("tbl%0d_sample", i), 64'(TIMER_SAMPLE), 64'(tbl[i].sample));
      chk($sformatf("tbl%0d_gid", i),    64'(grant_id),     64'(tbl[i].gid));
      chk($sformatf("tbl%0d_trst", i),   64'(TIMER_RST),    64'(tbl[i].trst));
    end

    // Contention: all four requesting continuously from a fresh reset.
    apply_reset();
    en = 1'b1;
    req = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (ack != 0) begin
        ack_cyc.push_back(k);
        ack_val.push_back(ack);
      end
    end
    req = '0;
    step();
    chk("cont_count", 64'(ack_cyc.size()), 64'd5);
    for (int i = 0; i < 5 && i < ack_cyc.size(); i++) begin
      chk($sformatf("cont_cyc%0d", i), 64'(ack_cyc[i]), 64'(3 + 4 * i));
      chk($sformatf("cont_ack%0d", i), 64'(ack_val[i]), 64'd1 << exp_ord[i]);
    end

    // Disabled counter: back-to-back samples return the same value.
    en = 1'b0;
    step(); step();
    ts_q.delete();
    req = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (ack != 0) ts_q.push_back(tstamp);
    end
    req = '0;
    step(); step();
    chk("dis_count", 64'(ts_q.size()), 64'd2);
    if (ts_q.size() == 2) chk("dis_equal", ts_q[1], ts_q[0]);

    // Enabled counter: back-to-back samples differ by exactly 4.
    en = 1'b1;
    step(); step();
    ts_q.delete();
    req = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (ack != 0) ts_q.push_back(tstamp);
    end
    req = '0;
    step(); step();
    chk("en_count", 64'(ts_q.size()), 64'd2);
    if (ts_q.size() == 2) chk("en_delta", ts_q[1] - ts_q[0], 64'd4);

    // Clear: grow the count, pulse clr, then sample a small value.
    for (int k = 0; k < 15; k++) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_timer_rst", 64'(TIMER_RST), 64'd1);
    req = 4'b0001;
    step(); step(); step();
    chk("clr_ack", 64'(ack), 64'd1);
    chk("clr_small", 64'(tstamp < 64'd10), 64'd1);
    req = '0;
    step();

    // Reset asserted during WAIT: immediate abort, no ack afterwards.
    req = 4'b0001;
    step(); step();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_ack",    64'(ack), 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_tstamp", tstamp, 64'd0);
    chk("rst_gid",    64'(grant_id), 64'd0);
    chk("rst_sample", 64'(TIMER_SAMPLE), 64'd0);
    chk("rst_enable", 64'(TIMER_ENABLE), 64'd0);
    chk("rst_trst",   64'(TIMER_RST), 64'd0);
    model_reset();
    req = '0;
    step(); step();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0010;
    step(); step(); step();
    chk("post_rst_ack", 64'(ack), 64'd2);
    req = '0;
    step();

    // Random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      req = N'($urandom);
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
